shift_collect_32: RTL
=====================

# shift_collect_32

Serial-to-parallel collector for the bit stream that leaves the 32-bit shifter's boundary outputs (`bb_left` / `bb_right`). It accepts one bit per cycle under a valid/ready handshake and assembles a 32-bit word in the same bit order the shifter emitted it. It presents the completed word on a valid/ready output port. It is the receiving end of the shifter's serial overflow path, used to capture and reconstruct shifted-out data.

## Interface
Parameters:
- `WIDTH`, default 32: word width; `count_out` is `$clog2(WIDTH)+1` bits wide.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `bit_in`, input, 1: serial data bit from a shifter boundary output.
- `bit_valid`, input, 1: `bit_in` is valid this cycle.
- `bit_ready`, output, 1: collector accepts a bit this cycle.
- `dir`, input, 1: stream direction.
  - 0 = bits come from a left shift (`bb_left`).
  - 1 = bits come from a right shift (`bb_right`).
- `word_out`, output, WIDTH: assembled word.
- `word_valid`, output, 1: `word_out` is complete and stable.
- `word_ready`, input, 1: consumer takes the word.
- `dir_out`, output, 1: direction latched for the current word.
- `count_out`, output, 6: number of bits held (0..32).
- `flush`, input, 1: present only with `SHIFT_COLLECT_FLUSH_EN` (see Configuration).

## Operation
States: FILL and HOLD.
- Reset state is FILL.

Bit acceptance:
- A bit is accepted when `bit_valid && bit_ready`.
- `bit_ready = (state == FILL)`.

Direction latch:
- `dir` is sampled into `dir_out` only on the first accepted bit of a word (`count_out == 0`).
- `dir` is ignored for the remaining bits of that word.

Shifting, one update per accepted bit:
- `dir_out = 0`: `word <= {word[WIDTH-2:0], bit_in}`. The first bit ends at the MSB, so the word reads in the order the left shift expelled it.
- `dir_out = 1`: `word <= {bit_in, word[WIDTH-1:1]}`. The first bit ends at the LSB.
- On each accepted bit, `count_out` increments.

FILL → HOLD:
- Taken when the WIDTH-th bit is accepted.
- On entry: `count_out = 32`, `word_valid = 1`.

HOLD:
- `bit_ready = 0`.
- `word_out`, `dir_out` and `count_out` are frozen.
- `word_valid` stays high until `word_valid && word_ready`.

HOLD → FILL:
- Taken on the handshake.
- `count_out <= 0` and `word_valid <= 0`.
- `word_out` retains its old value until overwritten by shifting.

Other rules:
- `word_ready` is ignored in FILL.
- `bit_valid` is ignored in HOLD; no bit is lost, because the source sees `bit_ready = 0`.
- No realignment or zero-clear of `word_out` is performed between words; every word fully overwrites all WIDTH bits.

## Timing
- All outputs are registered, except `bit_ready`, which decodes the state register combinationally.
- Reset values:
  - `word_out = 0`
  - `word_valid = 0`
  - `dir_out = 0`
  - `count_out = 0`
  - state FILL, so `bit_ready = 1`.
- Latency: `word_valid` rises the cycle after the 32nd bit is accepted.
- Minimum period per word is 33 cycles (32 bit cycles plus 1 handshake cycle). No bit is accepted in the handshake cycle.
- Reset asserted mid-word or in HOLD discards the partial or complete word immediately; there is no output handshake.
- Back-to-back streams: bits continuously valid are accepted on 32 consecutive cycles, then stalled until the handshake.

## Configuration
Macro: `SHIFT_COLLECT_FLUSH_EN`.

Defined:
- Adds the `flush` input.
- In FILL with `count_out > 0`, `flush = 1` moves to HOLD with the partial word.
- Bits already present stay where the shift placed them:
  - low `count_out` bits for `dir_out = 0`;
  - high `count_out` bits for `dir_out = 1`.
- Unused bits hold stale data. The consumer uses `count_out`.
- If a bit is accepted in the same cycle as `flush`, that bit is included (count+1), then HOLD is entered.
- `flush` with `count_out == 0` is ignored, as is `flush` in HOLD.

Undefined:
- No `flush` port; only full 32-bit words are produced.

## Test plan
- Reset release → `word_valid = 0`, `count_out = 0`, `bit_ready = 1`, `word_out = 0x00000000`.
- `dir = 0`, 32 bits of `0xA5A5F00F` MSB-first, `word_ready = 1` → `word_valid` one cycle after the last bit with `word_out = 0xA5A5F00F`; `count_out` returns to 0 the next cycle.
- `dir = 1`, 32 bits of `0x12345678` LSB-first, `word_ready` low for 5 cycles → `word_out = 0x12345678` held and `bit_ready = 0` for all 5 cycles, with `bit_valid` high throughout; the first new bit is accepted the cycle after the handshake.
- `dir` toggled after the first bit of a `dir = 0` word → `dir_out` stays 0 and shifting stays left for all 32 bits.
- Async `rst` pulse after 17 bits → outputs zero immediately; a following full word assembles correctly from `count_out = 0`.
- With `SHIFT_COLLECT_FLUSH_EN`: `dir = 0`, bits 1,0,1 then `flush` on the third bit's cycle → `word_valid = 1`, `count_out = 3`, `word_out[2:0] = 3'b101`.

Source files
------------

// File: rtl/shift_collect_32.sv
// Serial-to-parallel collector for the shifter's boundary bit stream (bb_left / bb_right).
// Optional macro SHIFT_COLLECT_FLUSH_EN adds a flush input that emits a partial word.
module shift_collect_32 #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    input  logic                     dir,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     dir_out,
    output logic [$clog2(WIDTH):0]   count_out
`ifdef SHIFT_COLLECT_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dir_q, dir_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;

    logic accept, last_bit, flush_go, handshake, dir_eff;

    assign accept    = bit_valid && (state_q == FILL);
    assign last_bit  = accept && (cnt_q == LAST_CNT);
    assign handshake = (state_q == HOLD) && word_ready;
    // Direction is captured only on the first bit of a word.
    assign dir_eff   = (cnt_q == '0) ? dir : dir_q;

`ifdef SHIFT_COLLECT_FLUSH_EN
    assign flush_go  = flush && (state_q == FILL) && (cnt_q != '0);
`else
    assign flush_go  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            word_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (last_bit || flush_go) state_d = HOLD;
            HOLD: if (word_ready)           state_d = FILL;
            default:                        state_d = FILL;
        endcase
    end

    always_comb begin
        word_d  = word_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        valid_d = (state_d == HOLD);
        if (accept) begin
            dir_d = dir_eff;
            cnt_d = cnt_q + CW'(1);
            if (dir_eff) word_d = {bit_in, word_q[WIDTH-1:1]};
            else         word_d = {word_q[WIDTH-2:0], bit_in};
        end
        // word_q is left stale on release; the next word overwrites it.
        if (handshake) cnt_d = '0;
    end

    assign bit_ready  = (state_q == FILL);
    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign dir_out    = dir_q;
    assign count_out  = cnt_q;

endmodule
